weight_pattern_gen8: RTL and testbench



---
 rtl/weight_pattern_gen8.sv | 162 ++++++++++++++++
 tb/tb_weight_pattern_gen8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_pattern_gen8.sv
// rtl/weight_pattern_gen8.sv - streams every 8-bit word of popcount K in ascending order
module weight_pattern_gen8 (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       start,
   input  logic [3:0] K,
   output logic       busy,
   output logic [7:0] O,
   output logic       valid,
   input  logic       ready,
   output logic       last,
   output logic [6:0] IDX,
   output logic       err
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_k;
   logic [7:0] r_o;
   logic [6:0] r_idx;
   logic       r_valid;
   logic       r_busy;
   logic       r_last;
   logic       r_err;

   state_t     w_state_n;
   logic [3:0] w_k_n;
   logic [7:0] w_o_n;
   logic [6:0] w_idx_n;
   logic       w_valid_n;
   logic       w_busy_n;
   logic       w_last_n;
   logic       w_err_n;

   logic [8:0] w_first_wide;
   logic [7:0] w_first;
   logic [7:0] w_top_in;
   logic [7:0] w_top_lat;
   logic [7:0] w_c;
   logic [7:0] w_r;
   logic [2:0] w_ctz;
   logic [7:0] w_next;
   logic       w_k_legal;
   logic       w_accept;

   // Trailing-zero count of a one-hot (or zero) byte; zero maps to 0.
   function automatic logic [2:0] f_ctz(input logic [7:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) n = i[2:0];
      end
      return n;
   endfunction

   // Smallest word of weight K: the low K bits set. Nine bits so K=8 yields 0xFF.
   assign w_first_wide = (9'd1 << K) - 9'd1;
   assign w_first      = w_first_wide[7:0];

   // Largest word of a weight: the top K bits set; K=0 gives 0x00, K=8 gives 0xFF.
   assign w_top_in  = ~(8'hFF >> K);
   assign w_top_lat = ~(8'hFF >> r_k);

   // Next larger word with the same popcount (Gosper's step on 8 bits).
   // c isolates the lowest set bit, r ripples it into the next zero, and the
   // bits that changed are shifted back down to refill the bottom.
   assign w_c    = r_o & (~r_o + 8'd1);
   assign w_r    = r_o + w_c;
   assign w_ctz  = f_ctz(w_c);
   assign w_next = (((w_r ^ r_o) >> 2) >> w_ctz) | w_r;

   assign w_k_legal = (K <= 4'd8);
   assign w_accept  = r_valid & ready;

   // State and output registers; every output is driven from a flop.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_state <= ST_IDLE;
         r_k     <= 4'd0;
         r_o     <= 8'h00;
         r_idx   <= 7'd0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_k     <= w_k_n;
         r_o     <= w_o_n;
         r_idx   <= w_idx_n;
         r_valid <= w_valid_n;
         r_busy  <= w_busy_n;
         r_last  <= w_last_n;
         r_err   <= w_err_n;
      end
   end

   // Next-state and next-output decode; holding is the default so stalls keep O/IDX/last.
   always_comb begin
      w_state_n = r_state;
      w_k_n     = r_k;
      w_o_n     = r_o;
      w_idx_n   = r_idx;
      w_valid_n = r_valid;
      w_busy_n  = r_busy;
      w_last_n  = r_last;
      w_err_n   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_k_legal) begin
                  w_state_n = ST_STREAM;
                  w_k_n     = K;
                  w_o_n     = w_first;
                  w_idx_n   = 7'd0;
                  w_valid_n = 1'b1;
                  w_busy_n  = 1'b1;
                  w_last_n  = (w_first == w_top_in);
               end else begin
                  w_err_n = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            // start is deliberately not looked at here; K stays as latched.
            if (w_accept) begin
               if (r_last) begin
                  w_state_n = ST_IDLE;
                  w_k_n     = 4'd0;
                  w_o_n     = 8'h00;
                  w_idx_n   = 7'd0;
                  w_valid_n = 1'b0;
                  w_busy_n  = 1'b0;
                  w_last_n  = 1'b0;
               end else begin
                  w_o_n    = w_next;
                  w_idx_n  = r_idx + 7'd1;
                  w_last_n = (w_next == w_top_lat);
               end
            end
         end

         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   assign busy  = r_busy;
   assign O     = r_o;
   assign valid = r_valid;
   assign last  = r_last;
   assign IDX   = r_idx;
   assign err   = r_err;

endmodule

// File: tb/tb_weight_pattern_gen8.sv
// tb/tb_weight_pattern_gen8.sv - self-checking bench for weight_pattern_gen8
module tb_weight_pattern_gen8;

   logic       CLK;
   logic       RESETN;
   logic       start;
   logic [3:0] K;
   logic       busy;
   logic [7:0] O;
   logic       valid;
   logic       ready;
   logic       last;
   logic [6:0] IDX;
   logic       err;

   int n_checks;
   int n_errors;

   weight_pattern_gen8 dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .start  (start),
      .K      (K),
      .busy   (busy),
      .O      (O),
      .valid  (valid),
      .ready  (ready),
      .last   (last),
      .IDX    (IDX),
      .err    (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int k;
      bit rnd;
      bit poke;
      int len;
      int first_w;
      int last_w;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: the n-th (zero-based) byte in ascending order whose popcount is k.
   function automatic int nth_word(input int k, input int n);
      int cnt;
      logic [7:0] b;
      cnt = 0;
      for (int v = 0; v < 256; v++) begin
         b = v[7:0];
         if ($countones(b) == k) begin
            if (cnt == n) return v;
            cnt++;
         end
      end
      return -1;
   endfunction

   function automatic int word_count(input int k);
      int cnt;
      logic [7:0] b;
      cnt = 0;
      for (int v = 0; v < 256; v++) begin
         b = v[7:0];
         if ($countones(b) == k) cnt++;
      end
      return cnt;
   endfunction

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_busy"},  busy,  0);
      chk({tag, "_last"},  last,  0);
      chk({tag, "_O"},     O,     0);
      chk({tag, "_IDX"},   IDX,   0);
   endtask

   // Issues start on the current negedge and follows the stream to the negedge
   // after its final handshake, which is the first cycle a new start may go in.
   task automatic run_stream(input int k, input bit rnd, input bit poke,
                             input int exp_len, input int exp_first, input int exp_last);
      int  n;
      int  idx;
      int  cyc;
      bit  poked;
      bit  r;
      if (exp_len == 0) begin
         start = 1'b1;
         K     = k[3:0];
         ready = 1'b0;
         @(negedge CLK);
         start = 1'b0;
         chk("err_pulse", err, 1);
         chk("err_valid", valid, 0);
         chk("err_busy", busy, 0);
         @(negedge CLK);
         chk("err_cleared", err, 0);
         chk("err_valid2", valid, 0);
         chk("err_busy2", busy, 0);
         return;
      end
      n     = word_count(k);
      idx   = 0;
      cyc   = 0;
      poked = 1'b0;
      start = 1'b1;
      K     = k[3:0];
      ready = 1'b0;
      @(negedge CLK);
      start = 1'b0;
      while (idx < n && cyc < 1000) begin
         chk("valid", valid, 1);
         chk("busy", busy, 1);
         chk("err_idle", err, 0);
         chk("word", O, nth_word(k, idx));
         chk("idx", IDX, idx);
         chk("last", last, (idx == n - 1));
         chk("popcount", $countones(O), k);
         if (idx == 0)     chk("first_word", O, exp_first);
         if (idx == n - 1) chk("last_word", O, exp_last);
         if (poke && idx == 3 && !poked) begin
            start = 1'b1;
            K     = 4'd5;
            poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         r     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ready = r;
         @(negedge CLK);
         cyc++;
         if (r) idx++;
      end
      start = 1'b0;
      ready = 1'b0;
      if (cyc >= 1000) chk("stream_timeout", cyc, 0);
      chk("stream_len", idx, exp_len);
      check_idle_zero("post_stream");
   endtask

   initial begin
      int cyc;
      n_checks = 0;
      n_errors = 0;
      RESETN   = 1'b0;
      start    = 1'b0;
      K        = 4'd0;
      ready    = 1'b0;

      vecs[0] = '{k: 3,  rnd: 1'b0, poke: 1'b0, len: 56, first_w: 'h07, last_w: 'hE0};
      vecs[1] = '{k: 0,  rnd: 1'b0, poke: 1'b0, len: 1,  first_w: 'h00, last_w: 'h00};
      vecs[2] = '{k: 8,  rnd: 1'b0, poke: 1'b0, len: 1,  first_w: 'hFF, last_w: 'hFF};
      vecs[3] = '{k: 9,  rnd: 1'b0, poke: 1'b0, len: 0,  first_w: 0,    last_w: 0};
      vecs[4] = '{k: 15, rnd: 1'b0, poke: 1'b0, len: 0,  first_w: 0,    last_w: 0};
      vecs[5] = '{k: 1,  rnd: 1'b0, poke: 1'b0, len: 8,  first_w: 'h01, last_w: 'h80};
      vecs[6] = '{k: 4,  rnd: 1'b1, poke: 1'b0, len: 70, first_w: 'h0F, last_w: 'hF0};
      vecs[7] = '{k: 7,  rnd: 1'b1, poke: 1'b0, len: 8,  first_w: 'h7F, last_w: 'hFE};
      vecs[8] = '{k: 6,  rnd: 1'b0, poke: 1'b0, len: 28, first_w: 'h3F, last_w: 'hFC};

      repeat (2) @(negedge CLK);
      check_idle_zero("reset");
      chk("reset_err", err, 0);
      RESETN = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 9; i++) begin
         run_stream(vecs[i].k, vecs[i].rnd, vecs[i].poke,
                    vecs[i].len, vecs[i].first_w, vecs[i].last_w);
      end

      // Abort a K=4 stream with reset at IDX=20.
      start = 1'b1;
      K     = 4'd4;
      ready = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      cyc   = 0;
      while (IDX != 7'd20 && cyc < 100) begin
         @(negedge CLK);
         cyc++;
      end
      chk("reach_idx20", IDX, 20);
      chk("word_idx20", O, nth_word(4, 20));
      RESETN = 1'b0;
      @(negedge CLK);
      check_idle_zero("midreset");
      chk("midreset_err", err, 0);
      RESETN = 1'b1;
      ready  = 1'b0;

      // K=2 with a K=5 start poked in mid-stream, then a back-to-back K=5 stream.
      run_stream(2, 1'b0, 1'b1, 28, 'h03, 'hC0);
      run_stream(5, 1'b0, 1'b0, 56, 'h1F, 'hF8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
